// File: rtl/rpn_uart_pkg.sv
// Shared constants for the RPN result-to-UART path: digit count, ASCII bytes,
// sequencer state encoding and small helpers.
package rpn_uart_pkg;

   localparam int NDIGITS = 6;
   localparam int DBUF_CW = $clog2(NDIGITS + 1);

   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_MINUS = 8'h2D;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   // Sequencer state encoding, also visible on the debug state port.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_SIGN    = 3'd3;
   localparam logic [2:0] ST_DIGITS  = 3'd4;
   localparam logic [2:0] ST_TERM_CR = 3'd5;
   localparam logic [2:0] ST_TERM_LF = 3'd6;

   function automatic logic [2:0] ptr_next(input logic [2:0] p);
      return (p == 3'(NDIGITS - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   // Digits above 9 are not rejected; the sum simply wraps in 8 bits.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return CHAR_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/result_tx_sequencer_if.sv
// Bundle of the request, converter and UART TX signals around the sequencer.
// Handshakes: a transfer happens on a cycle where valid && ready; valid, once
// raised, stays high with stable data until that transfer.
interface result_tx_sequencer_if;

   logic        req_valid;
   logic [15:0] req_data;
   logic        req_neg;
   logic        req_ready;

   logic        conv_wen;
   logic [15:0] conv_din;
   logic [3:0]  conv_dout;
   logic        conv_sending;
   logic        conv_leading_zero;

   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   modport slave (
      input  req_valid, req_data, req_neg, conv_dout, conv_sending,
             conv_leading_zero, tx_ready,
      output req_ready, conv_wen, conv_din, tx_valid, tx_data
   );

   modport master (
      output req_valid, req_data, req_neg, conv_dout, conv_sending,
             conv_leading_zero, tx_ready,
      input  req_ready, conv_wen, conv_din, tx_valid, tx_data
   );

endinterface

// File: rtl/digit_buffer.sv
// Small FIFO holding the significant BCD digits of one result, MSB first.
// Pushes when full and pops when empty are ignored.
module digit_buffer
   import rpn_uart_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               push_i,
   input  logic [3:0]         din_i,
   input  logic               pop_i,
   output logic [3:0]         head_o,
   output logic [DBUF_CW-1:0] count_o,
   output logic               empty_o
);

   logic [3:0]         mem_q [NDIGITS];
   logic [2:0]         wr_q;
   logic [2:0]         rd_q;
   logic [DBUF_CW-1:0] count_q;
   logic               do_push;
   logic               do_pop;

   assign do_push = push_i && (count_q != DBUF_CW'(NDIGITS));
   assign do_pop  = pop_i && (count_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < NDIGITS; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < NDIGITS; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ptr_next(wr_q);
         end
         if (do_pop) rd_q <= ptr_next(rd_q);
         count_q <= count_q + DBUF_CW'(do_push) - DBUF_CW'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/result_tx_sequencer.sv
// Fires the BCD converter once per accepted result, buffers its significant
// digits and streams "-", digits and the line terminator as ASCII to the UART.
module result_tx_sequencer
   import rpn_uart_pkg::*;
#(
   parameter bit TERM_CRLF = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   result_tx_sequencer_if.slave bus,
   output logic                 busy,
   output logic                 conv_err,
   output logic [2:0]           dbg_state_o
);

   localparam logic [2:0] LAST_IDX = 3'(NDIGITS - 1);

   logic [2:0]         state_q, state_d;
   logic [15:0]        din_q, din_d;
   logic               neg_q, neg_d;
   logic [2:0]         cap_cnt_q, cap_cnt_d;

   logic               buf_push;
   logic               buf_pop;
   logic               buf_clr;
   logic [3:0]         buf_head;
   logic [DBUF_CW-1:0] buf_count;
   logic               buf_empty;

   logic               conv_wen_c;
   logic               tx_valid_c;
   logic [7:0]         tx_data_c;
   logic               err_c;

   digit_buffer u_digit_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (buf_clr),
      .push_i  (buf_push),
      .din_i   (bus.conv_dout),
      .pop_i   (buf_pop),
      .head_o  (buf_head),
      .count_o (buf_count),
      .empty_o (buf_empty)
   );

   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      neg_d      = neg_q;
      cap_cnt_d  = cap_cnt_q;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_clr    = 1'b0;
      conv_wen_c = 1'b0;
      tx_valid_c = 1'b0;
      tx_data_c  = '0;
      err_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               din_d   = bus.req_data;
               neg_d   = bus.req_neg;
               state_d = ST_START;
            end
         end
         ST_START: begin
            conv_wen_c = 1'b1;
            cap_cnt_d  = '0;
            state_d    = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // The converter must stream a digit on every capture cycle.
            if (!bus.conv_sending) begin
               err_c   = 1'b1;
               buf_clr = 1'b1;
               state_d = ST_IDLE;
            end else begin
               buf_push = !bus.conv_leading_zero || (cap_cnt_q == LAST_IDX);
               if (cap_cnt_q == LAST_IDX) begin
                  state_d = neg_q ? ST_SIGN : ST_DIGITS;
               end else begin
                  cap_cnt_d = cap_cnt_q + 3'd1;
               end
            end
         end
         ST_SIGN: begin
            tx_valid_c = 1'b1;
            tx_data_c  = CHAR_MINUS;
            if (bus.tx_ready) state_d = ST_DIGITS;
         end
         ST_DIGITS: begin
            // The units digit is always pushed, so the buffer is never empty
            // here in normal operation; the guard only avoids a stuck state.
            if (buf_empty) begin
               state_d = TERM_CRLF ? ST_TERM_CR : ST_TERM_LF;
            end else begin
               tx_valid_c = 1'b1;
               tx_data_c  = digit_to_ascii(buf_head);
               if (bus.tx_ready) begin
                  buf_pop = 1'b1;
                  if (buf_count == DBUF_CW'(1)) begin
                     state_d = TERM_CRLF ? ST_TERM_CR : ST_TERM_LF;
                  end
               end
            end
         end
         ST_TERM_CR: begin
            tx_valid_c = 1'b1;
            tx_data_c  = CHAR_CR;
            if (bus.tx_ready) state_d = ST_TERM_LF;
         end
         ST_TERM_LF: begin
            tx_valid_c = 1'b1;
            tx_data_c  = CHAR_LF;
            if (bus.tx_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         din_q     <= '0;
         neg_q     <= 1'b0;
         cap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         din_q     <= din_d;
         neg_q     <= neg_d;
         cap_cnt_q <= cap_cnt_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.conv_wen  = conv_wen_c;
   assign bus.conv_din  = din_q;
   assign bus.tx_valid  = tx_valid_c;
   assign bus.tx_data   = tx_data_c;
   assign busy          = (state_q != ST_IDLE);
   assign conv_err      = err_c;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer: two instances (CR LF and LF-only
// terminators) share a behavioural BCD converter and one UART byte monitor.
module tb_result_tx_sequencer;
   import rpn_uart_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stimulus controls ----------------
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [15:0] req_data = '0;
   logic        req_neg = 1'b0;
   logic        tx_ready_cfg = 1'b1;
   logic        toggle_en = 1'b0;
   logic        phase = 1'b0;
   logic        hold_low = 1'b0;
   logic        tx_ready;

   always @(posedge clk) #1 phase = ~phase;
   assign tx_ready = tx_ready_cfg & (~toggle_en | phase);

   // ---------------- DUTs ----------------
   result_tx_sequencer_if if_a ();
   result_tx_sequencer_if if_b ();

   logic       busy_a, busy_b, err_a, err_b;
   logic [2:0] state_a, state_b;

   result_tx_sequencer #(.TERM_CRLF(1'b1)) u_dut_crlf (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (if_a.slave),
      .busy        (busy_a),
      .conv_err    (err_a),
      .dbg_state_o (state_a)
   );

   result_tx_sequencer #(.TERM_CRLF(1'b0)) u_dut_lf (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (if_b.slave),
      .busy        (busy_b),
      .conv_err    (err_b),
      .dbg_state_o (state_b)
   );

   // ---------------- converter model ----------------
   function automatic int p10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   logic        wen_any;
   logic [15:0] din_sel;
   int          cv_cnt = 0;
   int          cv_val = 0;
   int          cv_div;
   logic        cv_sending;
   logic [3:0]  cv_dout;
   logic        cv_lz;

   assign wen_any = if_a.conv_wen | if_b.conv_wen;
   assign din_sel = if_b.conv_wen ? if_b.conv_din : if_a.conv_din;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cv_cnt <= 0;
      else if (wen_any && !hold_low) begin
         cv_cnt <= NDIGITS;
         cv_val <= int'({16'h0, din_sel});
      end else if (cv_cnt > 0) cv_cnt <= cv_cnt - 1;
   end

   assign cv_div     = (cv_cnt > 0) ? cv_val / p10(cv_cnt - 1) : 0;
   assign cv_sending = (cv_cnt > 0);
   assign cv_dout    = 4'(cv_div % 10);
   assign cv_lz      = (cv_div == 0);

   assign if_a.req_valid = req_valid & ~sel;
   assign if_b.req_valid = req_valid & sel;
   assign if_a.req_data = req_data;
   assign if_b.req_data = req_data;
   assign if_a.req_neg = req_neg;
   assign if_b.req_neg = req_neg;
   assign if_a.tx_ready = tx_ready;
   assign if_b.tx_ready = tx_ready;
   assign if_a.conv_dout = cv_dout;
   assign if_b.conv_dout = cv_dout;
   assign if_a.conv_sending = cv_sending;
   assign if_b.conv_sending = cv_sending;
   assign if_a.conv_leading_zero = cv_lz;
   assign if_b.conv_leading_zero = cv_lz;

   logic        obs_req_ready, obs_tx_valid, obs_conv_wen, obs_busy, obs_err;
   logic [7:0]  obs_tx_data;
   logic [15:0] obs_conv_din;
   logic [2:0]  obs_state;

   assign obs_req_ready = sel ? if_b.req_ready : if_a.req_ready;
   assign obs_tx_valid  = sel ? if_b.tx_valid : if_a.tx_valid;
   assign obs_tx_data   = sel ? if_b.tx_data : if_a.tx_data;
   assign obs_conv_wen  = sel ? if_b.conv_wen : if_a.conv_wen;
   assign obs_conv_din  = sel ? if_b.conv_din : if_a.conv_din;
   assign obs_busy      = sel ? busy_b : busy_a;
   assign obs_err       = sel ? err_b : err_a;
   assign obs_state     = sel ? state_b : state_a;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // ---------------- monitor ----------------
   logic       stalled = 1'b0;
   logic [7:0] stall_data = '0;
   logic       prev_valid = 1'b0;
   int wen_cnt = 0, wen_at = 0, err_cnt = 0, err_at = 0;
   int rise_cnt = 0, rise_at = 0, stall_cnt = 0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stalled    = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (stalled) begin
            check("tx_hold_valid", 32'(obs_tx_valid), 32'd1);
            check("tx_hold_data", 32'(obs_tx_data), 32'(stall_data));
            stall_cnt++;
         end
         stalled    = obs_tx_valid && !tx_ready;
         stall_data = obs_tx_data;
         if (obs_tx_valid && tx_ready) got_q.push_back(obs_tx_data);
         if (obs_conv_wen) begin wen_cnt++; wen_at = cyc; end
         if (obs_err) begin err_cnt++; err_at = cyc; end
         if (obs_tx_valid && !prev_valid) begin rise_cnt++; rise_at = cyc; end
         prev_valid = obs_tx_valid;
      end
   end

   // ---------------- driver tasks ----------------
   int acc_at, idle_at, wen_base, err_base, rise_base;

   task automatic wait_ready(output int at);
      int k = 0;
      @(negedge clk);
      while (!obs_req_ready && k < 200) begin @(negedge clk); k++; end
      check("req_ready_wait", 32'(obs_req_ready), 32'd1);
      at = cyc;
   endtask

   task automatic start_job(input logic [15:0] d, input logic n);
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = d; req_neg = n;
      wait_ready(acc_at);
      wen_base = wen_cnt; err_base = err_cnt; rise_base = rise_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output int at);
      int k = 0;
      @(negedge clk);
      while (obs_busy && k < 300) begin @(negedge clk); k++; end
      check("idle_wait", 32'(obs_busy), 32'd0);
      check("req_ready_idle", 32'(obs_req_ready), 32'd1);
      at = cyc;
   endtask

   task automatic push_exp(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
   endtask

   task automatic compare_bytes(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic check_timing(input string tag, input int nbytes, input bit with_len);
      check({tag, "_wen_count"}, 32'(wen_cnt - wen_base), 32'd1);
      check({tag, "_wen_cycle"}, 32'(wen_at - acc_at), 32'd1);
      check({tag, "_tx_rises"}, 32'(rise_cnt - rise_base), 32'd1);
      check({tag, "_first_tx_cycle"}, 32'(rise_at - acc_at), 32'd8);
      if (with_len) check({tag, "_job_len"}, 32'(idle_at - acc_at), 32'(8 + nbytes));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_valid"}, 32'(obs_tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(obs_tx_data), 32'h0);
      check({tag, "_busy"}, 32'(obs_busy), 32'd0);
      check({tag, "_conv_wen"}, 32'(obs_conv_wen), 32'd0);
      check({tag, "_conv_din"}, 32'(obs_conv_din), 32'h0);
      check({tag, "_conv_err"}, 32'(obs_err), 32'd0);
      check({tag, "_req_ready"}, 32'(obs_req_ready), 32'd1);
      check({tag, "_state"}, 32'(obs_state), 32'(ST_IDLE));
   endtask

   // ---------------- test sequence ----------------
   int acc1, acc2;

   initial begin
      #12;
      check_reset_values("por");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1234, positive, CR LF, tx_ready held high
      start_job(16'd1234, 1'b0);
      wait_idle(idle_at);
      check_timing("j1234", 6, 1'b1);
      push_exp(64'h0000_3132_3334_0D0A, 6);
      compare_bytes("j1234_bytes");

      // zero with sign
      start_job(16'd0, 1'b1);
      wait_idle(idle_at);
      check_timing("jneg0", 4, 1'b1);
      push_exp(64'h0000_0000_2D30_0D0A, 4);
      compare_bytes("jneg0_bytes");

      // full-scale value with tx_ready toggling every cycle
      toggle_en = 1'b1;
      start_job(16'd65535, 1'b0);
      wait_idle(idle_at);
      toggle_en = 1'b0;
      check_timing("jmax", 7, 1'b0);
      check("jmax_stalls_seen", 32'(stall_cnt != 0), 32'd1);
      push_exp(64'h0036_3535_3335_0D0A, 7);
      compare_bytes("jmax_bytes");

      // converter never raises conv_sending
      hold_low = 1'b1;
      start_job(16'd42, 1'b0);
      wait_idle(idle_at);
      hold_low = 1'b0;
      check("jerr_err_count", 32'(err_cnt - err_base), 32'd1);
      check("jerr_err_cycle", 32'(err_at - acc_at), 32'd2);
      check("jerr_no_tx", 32'(rise_cnt - rise_base), 32'd0);
      check("jerr_idle_cycle", 32'(idle_at - acc_at), 32'd3);
      compare_bytes("jerr_bytes");

      // reset while stalled in the digit phase
      tx_ready_cfg = 1'b0;
      start_job(16'd4321, 1'b0);
      repeat (9) @(negedge clk);
      check("jrst_state_digits", 32'(obs_state), 32'(ST_DIGITS));
      check("jrst_first_digit", 32'(obs_tx_data), 32'h34);
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_job_rst");
      #1 rst_n = 1'b1;
      compare_bytes("jrst_bytes");

      // LF-only instance after reset
      sel = 1'b1;
      tx_ready_cfg = 1'b1;
      start_job(16'd7, 1'b0);
      wait_idle(idle_at);
      check_timing("jlf7", 2, 1'b1);
      push_exp(64'h0000_0000_0000_370A, 2);
      compare_bytes("jlf7_bytes");

      // back-to-back requests with req_valid held high
      sel = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = 16'd5; req_neg = 1'b0;
      wait_ready(acc1);
      @(posedge clk); #1;
      req_data = 16'd10;
      wait_ready(acc2);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_idle(idle_at);
      check("b2b_second_accept", 32'(acc2 - acc1), 32'd11);
      check("b2b_second_len", 32'(idle_at - acc2), 32'd12);
      push_exp(64'h0035_0D0A_3130_0D0A, 7);
      compare_bytes("b2b_bytes");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/result_tx_sequencer.md
# result_tx_sequencer

Controller that sequences the binary-to-decimal digit converter for one 16-bit RPN result and turns its digit stream into ASCII bytes for the UART transmitter. It accepts a result over a valid/ready handshake, fires the converter once, and captures the six digits it streams. It strips leading zeros, optionally prefixes '-', and appends a line terminator. It sits between the RPN evaluator's result port and the UART TX byte interface, and is the only driver of the converter's write enable.

## Interface
- NDIGITS, 6: digits streamed per conversion; fixed by the converter.
- TERM_CRLF, 1: 1 = append CR LF; 0 = append LF only.
- clk  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  result available.
- req_data  in  16  unsigned magnitude.
- req_neg  in  1  emit '-' before the digits.
- req_ready  out  1  high only in IDLE.
- conv_wen  out  1  one-cycle start pulse to the converter.
- conv_din  out  16  value to convert; held from acceptance until return to IDLE.
- conv_dout  in  4  current BCD digit.
- conv_sending  in  1  converter digit-valid/busy.
- conv_leading_zero  in  1  current digit and all earlier digits are zero.
- tx_valid  out  1  byte available to the UART.
- tx_data  out  8  ASCII byte.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  state != IDLE.
- conv_err  out  1  one-cycle pulse on a converter protocol violation.

## Operation
- States: IDLE → START → CAPTURE → SIGN → DIGITS → TERM_CR → TERM_LF → IDLE.
  - SIGN is skipped when the latched neg is 0.
  - TERM_CR is skipped when TERM_CRLF = 0.
- IDLE:
  - On req_valid && req_ready, latch req_data into conv_din and req_neg, then go to START.
- START:
  - conv_wen = 1 for exactly this one cycle, then go to CAPTURE.
- CAPTURE:
  - Every cycle with conv_sending = 1, sample conv_dout and conv_leading_zero.
  - Push the digit into the digit buffer unless conv_leading_zero = 1 and the digit is not the NDIGITS-th.
  - The final (units) digit is always pushed, so a value of 0 prints "0".
  - After NDIGITS samples, go to SIGN or DIGITS.
- Protocol errors, checked in CAPTURE:
  - conv_sending = 0 on the first CAPTURE cycle, or falling before NDIGITS samples, is an error.
  - On error: pulse conv_err, clear the buffer, return to IDLE; no bytes are sent.
- SIGN / DIGITS / TERM_CR / TERM_LF:
  - tx_data = 0x2D, then 0x30 + digit (pushed order, MSB first), then 0x0D, then 0x0A.
- TX handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_valid stays high and tx_data stays stable until that transfer; tx_valid is never withdrawn.
  - The next byte is presented on the cycle after the transfer. tx_valid may stay high back-to-back.
- DIGITS ends after the last buffered digit transfers.
- Digit values above 9 are not checked; the byte sent is 0x30 + value truncated to 8 bits.
- req_ready = 0 throughout a job; a new request waits until IDLE.

## Timing
- Reset values (asynchronous, on rst_n low):
  - State returns to IDLE and the digit buffer clears.
  - conv_wen, tx_valid, busy and conv_err are 0; tx_data = 0 and conv_din = 0.
  - req_ready = 1 while in IDLE.
- Reset mid-job aborts immediately; no partial terminator is sent.
- Job timeline, cycle 0 = request accepted:
  - Cycle 1: conv_wen = 1.
  - Cycles 2–7: conv_sending = 1, digits captured.
  - Cycle 8: first tx_valid.
- Minimum job length with tx_ready held at 1: 8 + N_bytes cycles. busy falls on the cycle after the last transfer.
- req_ready returns to 1 on the cycle after the final LF transfer, so back-to-back jobs have no extra gap.
- Maximum bytes per job: 1 sign + 5 digits + 2 terminator = 8.

## Structure
- Package rpn_uart_pkg holds:
  - the state enum;
  - ASCII constants CHAR_ZERO = 8'h30, CHAR_MINUS = 8'h2D, CHAR_CR = 8'h0D, CHAR_LF = 8'h0A;
  - NDIGITS.
- Sub-module digit_buffer: 6 × 4-bit FIFO with push, pop, count and empty. It is cleared on reset and on error.
- The converter is instantiated next to this block at the top level, not inside it.

## Test plan
- req_data = 1234, neg = 0, TERM_CRLF = 1, tx_ready held at 1 → bytes 31 32 33 34 0D 0A; first tx_valid at cycle 8; conv_wen high for exactly 1 cycle.
- req_data = 0, neg = 1 → bytes 2D 30 0D 0A.
- req_data = 65535 with tx_ready toggling 1/0 every cycle → bytes 36 35 35 33 35 0D 0A; tx_data stable while stalled.
- Converter model holds conv_sending low after conv_wen → conv_err pulse at cycle 2; no tx_valid; req_ready = 1 at cycle 3.
- rst_n pulsed low during the DIGITS state → all outputs go to reset values asynchronously; the next request for 7 with TERM_CRLF = 0 → bytes 37 0A.
- Two back-to-back requests (5, then 10) with req_valid held high → 35 0D 0A 31 30 0D 0A; the second is accepted the cycle after the first LF transfer.
